// File: rtl/parking_pkg.sv
// Shared types and sensor patterns for the two-beam parking sensor driver.
// Patterns are {outer, inner}; each sequence step changes exactly one beam.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    GAP,
    REJ
  } state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam logic [1:0] SENSE_CLEAR = 2'b00;
  localparam logic [1:0] ENTRY_SEQ [3] = '{2'b10, 2'b11, 2'b01};
  localparam logic [1:0] EXIT_SEQ  [3] = '{2'b01, 2'b11, 2'b10};

  function automatic logic [1:0] sense_pattern(input state_t s, input logic dir);
    logic [1:0] p;
    p = SENSE_CLEAR;
    case (s)
      PH1:     p = (dir == DIR_EXIT) ? EXIT_SEQ[0] : ENTRY_SEQ[0];
      PH2:     p = (dir == DIR_EXIT) ? EXIT_SEQ[1] : ENTRY_SEQ[1];
      PH3:     p = (dir == DIR_EXIT) ? EXIT_SEQ[2] : ENTRY_SEQ[2];
      default: p = SENSE_CLEAR;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parking_dwell_timer.sv
// Loadable down-counter; expire marks the last cycle of each dwell period.
module parking_dwell_timer #(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(DWELL + 1);
  localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/parking_sensor_driver.sv
// Emulates vehicle entry/exit beam-break waveforms on the two sensor lines
// and tracks the occupancy it has produced.
module parking_sensor_driver
  import parking_pkg::*;
#(
  parameter int unsigned DWELL    = 2,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned CAPACITY = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  output logic             cmd_ready,
  output logic [1:0]       btn,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic [CNT_W-1:0] occ
);

  state_t state, state_next;
  logic   dir_q, dir_next;
  logic   accept, load, expire;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == PH1) || (state == PH2) || (state == PH3) || (state == GAP);
  assign done      = (state == GAP) && expire && !rst;
  assign reject    = (state == REJ);

  parking_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (busy),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    dir_next   = dir_q;
    case (state)
      IDLE: begin
        if (accept) begin
          dir_next = cmd_dir;
          if (((cmd_dir == DIR_ENTRY) && (occ == CNT_W'(CAPACITY))) ||
              ((cmd_dir == DIR_EXIT)  && (occ == '0))) begin
            state_next = REJ;
          end else begin
            state_next = PH1;
            load       = 1'b1;
          end
        end
      end
      PH1: if (expire) begin state_next = PH2; load = 1'b1; end
      PH2: if (expire) begin state_next = PH3; load = 1'b1; end
      PH3: if (expire) begin state_next = GAP; load = 1'b1; end
      GAP: if (expire) state_next = IDLE;
      REJ: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // btn is registered from the next state so it lines up with the phase it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir_q <= DIR_ENTRY;
      btn   <= SENSE_CLEAR;
      occ   <= '0;
    end else begin
      state <= state_next;
      dir_q <= dir_next;
      btn   <= sense_pattern(state_next, dir_next);
      if ((state == GAP) && expire) begin
        occ <= (dir_q == DIR_EXIT) ? occ - 1'b1 : occ + 1'b1;
      end
    end
  end

endmodule
